// File: rtl/reset_sequencer.sv
// Per-clock-domain reset sequencer: releases STAGES subsystem resets in order, waiting for each
// stage's ready acknowledge, retrying on timeout and latching a fault when retries run out.
module reset_sequencer #(
    parameter int unsigned STAGES         = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic              clock,
    input  logic              areset_n,
    input  logic              reset_req,
    input  logic [STAGES-1:0] stage_ready,
    output logic [STAGES-1:0] stage_reset,
    output logic              sys_ready,
    output logic              fault,
    output logic [3:0]        retry_count,
    output logic [2:0]        state_code
);

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IdxW  = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [2:0] {
        StHold  = 3'd0,
        StGap   = 3'd1,
        StWait  = 3'd2,
        StDone  = 3'd3,
        StFault = 3'd4
    } state_e;

    state_e            state_q;
    logic [HoldW-1:0]  hold_cnt_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic [TmoW-1:0]   tmo_cnt_q;
    logic [IdxW-1:0]   idx_q;

    assign state_code = state_q;

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= StHold;
            stage_reset <= '1;
            sys_ready   <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            idx_q       <= '0;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else if (reset_req) begin
            state_q     <= StHold;
            stage_reset <= '1;
            sys_ready   <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            idx_q       <= '0;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (hold_cnt_q == HoldW'(HOLD_CYCLES - 1)) begin
                        hold_cnt_q <= '0;
                        gap_cnt_q  <= '0;
                        idx_q      <= '0;
                        state_q    <= StGap;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                        gap_cnt_q          <= '0;
                        stage_reset[idx_q] <= 1'b0;
                        tmo_cnt_q          <= '0;
                        state_q            <= StWait;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                StWait: begin
                    // A ready sample on the timeout edge still counts as success.
                    if (stage_ready[idx_q]) begin
                        if (idx_q == IdxW'(STAGES - 1)) begin
                            sys_ready   <= 1'b1;
                            retry_count <= '0;
                            state_q     <= StDone;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end
                    end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        stage_reset <= '1;
                        idx_q       <= '0;
                        tmo_cnt_q   <= '0;
                        hold_cnt_q  <= '0;
                        if (retry_count < 4'(MAX_RETRIES)) begin
                            retry_count <= retry_count + 4'd1;
                            state_q     <= StHold;
                        end else begin
                            fault   <= 1'b1;
                            state_q <= StFault;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // Loss of any ready is a spontaneous drop, not a retry.
                    if (!(&stage_ready)) begin
                        sys_ready   <= 1'b0;
                        stage_reset <= '1;
                        idx_q       <= '0;
                        hold_cnt_q  <= '0;
                        state_q     <= StHold;
                    end
                end
                StFault: begin
                    fault       <= 1'b1;
                    stage_reset <= '1;
                    sys_ready   <= 1'b0;
                end
                default: begin
                    stage_reset <= '1;
                    sys_ready   <= 1'b0;
                    idx_q       <= '0;
                    hold_cnt_q  <= '0;
                    state_q     <= StHold;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: an anchor/deadline model checked every cycle, plus directed
// scenarios with hand-computed edge numbers.
module tb_reset_sequencer;

    localparam int STAGES = 4;
    localparam int HOLD   = 16;
    localparam int GAP    = 8;
    localparam int TMO    = 1024;
    localparam int MAXR   = 3;

    logic              clock       = 1'b0;
    logic              areset_n    = 1'b0;
    logic              reset_req   = 1'b1;
    logic [STAGES-1:0] stage_ready = '0;
    logic [STAGES-1:0] stage_reset;
    logic              sys_ready;
    logic              fault;
    logic [3:0]        retry_count;
    logic [2:0]        state_code;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .STAGES        (STAGES),
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clock      (clock),
        .areset_n   (areset_n),
        .reset_req  (reset_req),
        .stage_ready(stage_ready),
        .stage_reset(stage_reset),
        .sys_ready  (sys_ready),
        .fault      (fault),
        .retry_count(retry_count),
        .state_code (state_code)
    );

    always #5 clock = ~clock;

    // Model: everything is timed from an anchor edge (last HOLD entry or last handshake).
    int cyc     = 0;
    int anchor  = 0;
    int n_ack   = 0;
    int retries = 0;
    bit waiting = 0;
    bit done    = 0;
    bit faulted = 0;
    int t0      = 0;

    function automatic void to_hold();
        anchor  = cyc;
        n_ack   = 0;
        waiting = 0;
        done    = 0;
        faulted = 0;
    endfunction

    always @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            to_hold();
            retries = 0;
        end else begin
            cyc++;
            if (reset_req) begin
                to_hold();
                retries = 0;
            end else if (faulted) begin
                faulted = 1;
            end else if (done) begin
                if (stage_ready != '1) to_hold();
            end else if (waiting) begin
                if (stage_ready[n_ack]) begin
                    n_ack++;
                    waiting = 0;
                    anchor  = cyc;
                    if (n_ack == STAGES) begin
                        done    = 1;
                        retries = 0;
                    end
                end else if (cyc - anchor == TMO) begin
                    if (retries < MAXR) begin
                        retries++;
                        to_hold();
                    end else begin
                        to_hold();
                        faulted = 1;
                    end
                end
            end else if (cyc == anchor + ((n_ack == 0) ? HOLD + GAP : GAP)) begin
                waiting = 1;
                anchor  = cyc;
            end
        end
    end

    function automatic logic [STAGES-1:0] exp_reset();
        logic [STAGES-1:0] m = '1;
        if (done) return '0;
        if (faulted) return '1;
        return m << (n_ack + int'(waiting));
    endfunction

    function automatic int exp_state();
        if (faulted) return 4;
        if (done) return 3;
        if (waiting) return 2;
        if (n_ack == 0 && cyc - anchor < HOLD) return 0;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        chk("stage_reset", 16'(stage_reset), 16'(exp_reset()));
        chk("sys_ready", 16'(sys_ready), 16'(done));
        chk("fault", 16'(fault), 16'(faulted));
        chk("retry_count", 16'(retry_count), 16'(retries));
        chk("state_code", 16'(state_code), 16'(exp_state()));
    end

    // Stage responder: ready rises lat[k] cycles after release (-1 never, -2 always high).
    int lat[STAGES]  = '{3, 3, 3, 3};
    int rcnt[STAGES] = '{default: 0};
    bit drop2        = 0;

    always @(negedge clock) begin
        #1;
        for (int k = 0; k < STAGES; k++) begin
            if (stage_reset[k]) rcnt[k] = 0;
            else rcnt[k]++;
            if (lat[k] == -2) stage_ready[k] = 1'b1;
            else if (lat[k] < 0 || stage_reset[k]) stage_ready[k] = 1'b0;
            else stage_ready[k] = (rcnt[k] > lat[k]);
            if (k == 2 && drop2) stage_ready[k] = 1'b0;
        end
    end

    // what: 0..STAGES-1 stage release, 4 sys_ready high, 5 fault high.
    task automatic wait_for(input int what, input int bound, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clock);
            #1;
            if (what < STAGES) hit = !stage_reset[what];
            else if (what == 4) hit = sys_ready;
            else hit = fault;
            if (hit === 1'b1) begin
                at = cyc - t0;
                break;
            end
        end
    endtask

    task automatic pulse_req();
        @(negedge clock);
        reset_req = 1'b1;
        @(negedge clock);
        reset_req = 1'b0;
        t0 = cyc;
    endtask

    int at;

    initial begin
        repeat (3) @(negedge clock);
        areset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset stage_reset", 16'(stage_reset), 16'hF);
        chk("reset state_code", 16'(state_code), 16'd0);

        // Nominal sequence, ready 3 cycles after each release.
        reset_req = 1'b0;
        t0 = cyc;
        wait_for(0, 200, at); chk("nom rel0 edge", 16'(at), 16'd24);
        wait_for(1, 200, at); chk("nom rel1 edge", 16'(at), 16'd36);
        wait_for(2, 200, at); chk("nom rel2 edge", 16'(at), 16'd48);
        wait_for(3, 200, at); chk("nom rel3 edge", 16'(at), 16'd60);
        wait_for(4, 200, at); chk("nom sys_ready edge", 16'(at), 16'd64);
        chk("nom retry_count", 16'(retry_count), 16'd0);

        // Glitch: 10 low, 1 high, then low.
        @(negedge clock); reset_req = 1'b1;
        @(negedge clock); reset_req = 1'b0;
        repeat (10) @(negedge clock);
        chk("glitch still HOLD", 16'(state_code), 16'd0);
        reset_req = 1'b1;
        @(negedge clock); reset_req = 1'b0;
        t0 = cyc;
        wait_for(0, 200, at); chk("glitch rel0 edge", 16'(at), 16'd24);
        wait_for(4, 200, at); chk("glitch sys_ready edge", 16'(at), 16'd64);

        // Drop stage_ready[2] for one cycle while DONE.
        @(negedge clock); drop2 = 1;
        @(posedge clock); #1; drop2 = 0;
        t0 = cyc;
        chk("drop sys_ready", 16'(sys_ready), 16'd0);
        chk("drop stage_reset", 16'(stage_reset), 16'hF);
        chk("drop state_code", 16'(state_code), 16'd0);
        wait_for(4, 200, at); chk("drop resequence edge", 16'(at), 16'd64);

        // Immediate ready on stage 2, stage 3 ready held high before release.
        lat = '{3, 3, 0, -2};
        pulse_req();
        wait_for(2, 200, at); chk("fast rel2 edge", 16'(at), 16'd48);
        wait_for(3, 200, at); chk("fast rel3 edge", 16'(at), 16'd57);
        wait_for(4, 200, at); chk("fast sys_ready edge", 16'(at), 16'd58);

        // Async reset while waiting on stage 2.
        lat = '{3, 3, -1, 3};
        pulse_req();
        wait_for(2, 200, at); chk("areset rel2 edge", 16'(at), 16'd48);
        repeat (5) @(posedge clock);
        #2 areset_n = 1'b0;
        #1;
        chk("areset stage_reset", 16'(stage_reset), 16'hF);
        chk("areset state_code", 16'(state_code), 16'd0);
        chk("areset sys_ready", 16'(sys_ready), 16'd0);
        chk("areset retry_count", 16'(retry_count), 16'd0);
        @(negedge clock); areset_n = 1'b1;

        // Stage 1 never ready: three retries then FAULT.
        lat = '{3, -1, 3, 3};
        pulse_req();
        wait_for(5, 6000, at); chk("fault edge", 16'(at), 16'd4240);
        chk("fault retry_count", 16'(retry_count), 16'd3);
        chk("fault stage_reset", 16'(stage_reset), 16'hF);
        chk("fault state_code", 16'(state_code), 16'd4);
        @(negedge clock); reset_req = 1'b1;
        @(posedge clock); #1;
        chk("clear fault", 16'(fault), 16'd0);
        chk("clear retry_count", 16'(retry_count), 16'd0);

        // Stage 0 ready first seen on the timeout sample.
        @(negedge clock);
        lat = '{TMO - 1, 3, 3, 3};
        reset_req = 1'b0;
        t0 = cyc;
        wait_for(1, 2000, at); chk("tmo-edge rel1 edge", 16'(at), 16'd1056);
        chk("tmo-edge retry_count", 16'(retry_count), 16'd0);
        wait_for(4, 200, at); chk("tmo-edge sys_ready edge", 16'(at), 16'd1084);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
